// File: rtl/uart_rx_word_fifo.sv
// UART byte-to-word packer: assembles four good bytes into a little-endian
// 32-bit word and queues completed words in a circular FIFO drained by valid/ready.
module uart_rx_word_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_ferr,
  input  logic                     flush,
  output logic [31:0]              word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     partial,
  output logic                     overflow,
  output logic [7:0]               ferr_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] B0 = 2'd0;
  localparam logic [1:0] B1 = 2'd1;
  localparam logic [1:0] B2 = 2'd2;
  localparam logic [1:0] B3 = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [23:0]   bytes_q, bytes_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   word_data_q, word_data_d;
  logic          word_valid_q, word_valid_d;
  logic [PW-1:0] level_q, level_d;
  logic          partial_q, partial_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    ferr_q, ferr_d;

  logic [31:0]   mem [DEPTH];

  logic          byte_good;
  logic          byte_err;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic [31:0]   new_word;

  // Next-state logic for assembler, FIFO pointers and registered outputs
  always_comb begin
    state_d      = state_q;
    bytes_d      = bytes_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    level_d      = level_q;
    partial_d    = partial_q;
    overflow_d   = overflow_q;
    ferr_d       = ferr_q;

    byte_good = rx_valid & ~rx_ferr & ~flush;
    byte_err  = rx_valid &  rx_ferr & ~flush;
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = word_valid_q & word_ready & ~flush;
    push_req  = byte_good & (state_q == B3);
    push      = push_req & (~full | pop);
    new_word  = {rx_data, bytes_q};

    if (flush) begin
      state_d      = B0;
      bytes_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      word_data_d  = '0;
      word_valid_d = 1'b0;
      level_d      = '0;
      overflow_d   = 1'b0;
      ferr_d       = '0;
    end else begin
      if (byte_err) begin
        state_d = B0;
        if (ferr_q != 8'hFF) ferr_d = ferr_q + 8'd1;
      end else if (byte_good) begin
        case (state_q)
          B0:      begin bytes_d[7:0]   = rx_data; state_d = B1; end
          B1:      begin bytes_d[15:8]  = rx_data; state_d = B2; end
          B2:      begin bytes_d[23:16] = rx_data; state_d = B3; end
          default: state_d = B0;
        endcase
      end

      if (push_req && !push) overflow_d = 1'b1;

      wr_ptr_d     = wr_ptr_q + PW'(push);
      rd_ptr_d     = rd_ptr_q + PW'(pop);
      level_d      = wr_ptr_d - rd_ptr_d;
      word_valid_d = (wr_ptr_d != rd_ptr_d);
      // Head is being written this cycle when the new read slot equals the write slot
      if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
        word_data_d = new_word;
      else
        word_data_d = mem[rd_ptr_d[AW-1:0]];
    end

    partial_d = (state_d != B0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= B0;
      bytes_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      level_q      <= '0;
      partial_q    <= 1'b0;
      overflow_q   <= 1'b0;
      ferr_q       <= '0;
    end else begin
      state_q      <= state_d;
      bytes_q      <= bytes_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      level_q      <= level_d;
      partial_q    <= partial_d;
      overflow_q   <= overflow_d;
      ferr_q       <= ferr_d;
    end
  end

  // Storage array; contents are don't-care until a pointer covers them
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr_q[AW-1:0]] <= new_word;
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign level      = level_q;
  assign partial    = partial_q;
  assign overflow   = overflow_q;
  assign ferr_count = ferr_q;

endmodule
